// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and busy-bit scoreboard for the decode-stage register file.
// Round-robin merges the ALU and load write-back paths onto the single write port.
module regfile_wb_sched #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rs,
    input  logic [AW-1:0] issue_rt,
    input  logic [AW-1:0] issue_rd,
    input  logic          issue_wr,
    output logic          issue_stall,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_rd,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_rd,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic [AW-1:0] rf_rd,
    output logic [DW-1:0] rf_writedata,
    output logic          rf_regwrite,
    output logic [AW:0]   busy_count,
    output logic          wb_err
);
    localparam int NREG = 1 << AW;

    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     busy_count_q, busy_count_d;
    logic            wb_err_q, wb_err_d;
    logic            rr_q, rr_d;
    logic [AW-1:0]   rf_rd_q, rf_rd_d;
    logic [DW-1:0]   rf_writedata_q, rf_writedata_d;
    logic            rf_regwrite_q, rf_regwrite_d;

    logic            grant0, grant1, any_grant, accept;
    logic [AW-1:0]   gnt_rd;
    logic [DW-1:0]   gnt_data;

    // Stall looks only at registered busy bits: a clear in this cycle is not bypassed.
    assign issue_stall = issue_valid &&
                         (busy_q[issue_rs] || busy_q[issue_rt] || (issue_wr && busy_q[issue_rd]));
    assign accept      = issue_valid && !issue_stall;

    // rr_q == 0 favours the ALU path when both requesters contend.
    assign grant0    = req0_valid && (!req1_valid || !rr_q);
    assign grant1    = req1_valid && (!req0_valid ||  rr_q);
    assign any_grant = grant0 || grant1;
    assign gnt_rd    = grant1 ? req1_rd   : req0_rd;
    assign gnt_data  = grant1 ? req1_data : req0_data;

    assign req0_ready   = grant0;
    assign req1_ready   = grant1;
    assign rf_rd        = rf_rd_q;
    assign rf_writedata = rf_writedata_q;
    assign rf_regwrite  = rf_regwrite_q;
    assign busy_count   = busy_count_q;
    assign wb_err       = wb_err_q;

    always_comb begin
        busy_d         = busy_q;
        wb_err_d       = wb_err_q;
        rr_d           = rr_q;
        rf_rd_d        = rf_rd_q;
        rf_writedata_d = rf_writedata_q;
        rf_regwrite_d  = 1'b0;

        if (any_grant) begin
            rf_rd_d        = gnt_rd;
            rf_writedata_d = gnt_data;
            rf_regwrite_d  = (gnt_rd != '0);
            if (gnt_rd != '0) begin
                if (!busy_q[gnt_rd]) begin
                    wb_err_d = 1'b1;
                end
                busy_d[gnt_rd] = 1'b0;
            end
        end

        if (req0_valid && req1_valid) begin
            rr_d = ~rr_q;
        end

        // Applied after the clear so that a set on the same register wins.
        if (accept && issue_wr && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        busy_count_d = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_count_d = busy_count_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q         <= '0;
            busy_count_q   <= '0;
            wb_err_q       <= 1'b0;
            rr_q           <= 1'b0;
            rf_rd_q        <= '0;
            rf_writedata_q <= '0;
            rf_regwrite_q  <= 1'b0;
        end else begin
            busy_q         <= busy_d;
            busy_count_q   <= busy_count_d;
            wb_err_q       <= wb_err_d;
            rr_q           <= rr_d;
            rf_rd_q        <= rf_rd_d;
            rf_writedata_q <= rf_writedata_d;
            rf_regwrite_q  <= rf_regwrite_d;
        end
    end
endmodule
